// File: rtl/demux_1x2_buffered_if.sv
// rtl/demux_1x2_buffered_if.sv - stream bundle for the buffered 1-to-2 distributor
interface demux_1x2_buffered_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    i_valid;
  logic [DATA_WIDTH-1:0]   i_data_bus;
  logic                    o_ready;
  logic                    i_en;
  logic [1:0]              i_cmd;
  logic [1:0]              o_valid;
  logic [2*DATA_WIDTH-1:0] o_data_bus;
  logic [1:0]              i_ready;

  modport master (
    output i_valid, i_data_bus, i_en, i_cmd, i_ready,
    input  o_ready, o_valid, o_data_bus
  );

  modport slave (
    input  i_valid, i_data_bus, i_en, i_cmd, i_ready,
    output o_ready, o_valid, o_data_bus
  );
endinterface

// File: rtl/demux_1x2_buffered.sv
// rtl/demux_1x2_buffered.sv - registered 1-to-2 distributor with a small FIFO per branch
module demux_1x2_buffered #(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 2,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1x2_buffered_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [COMMAND_WIDTH-1:0] cmd;
  logic [1:0]               full;
  logic [1:0]               empty;
  logic                     ready;
  logic                     accept;

  assign cmd = bus.i_cmd;

  // Multicast is all-or-nothing, so both branches must have room for cmd 11.
  always_comb begin
    ready = 1'b0;
    if (bus.i_en) begin
      case (cmd)
        2'b00:   ready = 1'b1;
        2'b01:   ready = ~full[0];
        2'b10:   ready = ~full[1];
        default: ready = ~full[0] & ~full[1];
      endcase
    end
  end

  assign bus.o_ready = ready;
  assign accept      = bus.i_valid & ready;

  for (genvar b = 0; b < 2; b++) begin : g_branch
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  push;
    logic                  pop;

    assign full[b]  = (cnt == CW'(FIFO_DEPTH));
    assign empty[b] = (cnt == '0);
    assign push     = accept & cmd[b];
    assign pop      = ~empty[b] & bus.i_ready[b];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= bus.i_data_bus;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    // Idle branches present zeros rather than stale storage contents.
    assign bus.o_valid[b] = ~empty[b];
    assign bus.o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = empty[b] ? '0 : mem[rd_ptr];
  end
endmodule

// File: tb/tb_demux_1x2_buffered.sv
// tb/tb_demux_1x2_buffered.sv - directed self-checking bench for demux_1x2_buffered
module tb_demux_1x2_buffered;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  demux_1x2_buffered_if #(.DATA_WIDTH(DW)) bus ();

  demux_1x2_buffered #(
    .DATA_WIDTH(DW),
    .COMMAND_WIDTH(2),
    .FIFO_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d);
    bus.i_valid    = v;
    bus.i_cmd      = c;
    bus.i_data_bus = d;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_en       = 1'b1;
    bus.i_ready    = 2'b00;
    drive(1'b1, 2'b11, 32'hDEAD);
    tick();
    tick();
    check("rst_valid", 64'(bus.o_valid), 64'h0);
    check("rst_data", bus.o_data_bus, 64'h0);
    rst = 1'b0;
    drive(1'b0, 2'b11, 32'h0);
    check("post_rst_ready", 64'(bus.o_ready), 64'h1);
    check("post_rst_nowrite", 64'(bus.o_valid), 64'h0);

    // Unicast low
    bus.i_ready = 2'b11;
    drive(1'b1, 2'b01, 32'hA5);
    check("uni_ready", 64'(bus.o_ready), 64'h1);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check("uni_valid", 64'(bus.o_valid), 64'h1);
    check("uni_data", bus.o_data_bus, 64'h0000_0000_0000_00A5);
    tick();
    check("uni_drained", 64'(bus.o_valid), 64'h0);

    // Multicast
    drive(1'b1, 2'b11, 32'h11);
    tick();
    check("mc1_valid", 64'(bus.o_valid), 64'h3);
    check("mc1_data", bus.o_data_bus, 64'h0000_0011_0000_0011);
    drive(1'b1, 2'b11, 32'h22);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check("mc2_valid", 64'(bus.o_valid), 64'h3);
    check("mc2_data", bus.o_data_bus, 64'h0000_0022_0000_0022);
    tick();
    check("mc_drained", 64'(bus.o_valid), 64'h0);

    // Backpressure on high branch
    bus.i_ready = 2'b00;
    drive(1'b1, 2'b10, 32'h1);
    check("bp_rdy1", 64'(bus.o_ready), 64'h1);
    tick();
    drive(1'b1, 2'b10, 32'h2);
    check("bp_rdy2", 64'(bus.o_ready), 64'h1);
    tick();
    drive(1'b1, 2'b10, 32'h3);
    check("bp_rdy3_full", 64'(bus.o_ready), 64'h0);
    check("bp_head1", bus.o_data_bus, 64'h0000_0001_0000_0000);
    drive(1'b1, 2'b11, 32'h3);
    check("bp_mc_refused", 64'(bus.o_ready), 64'h0);
    tick();
    check("bp_low_empty", 64'(bus.o_valid), 64'h2);
    check("bp_head1_hold", bus.o_data_bus, 64'h0000_0001_0000_0000);
    bus.i_ready = 2'b10;
    #1;
    check("bp_no_bypass", 64'(bus.o_ready), 64'h0);
    tick();
    check("bp_head2", bus.o_data_bus, 64'h0000_0002_0000_0000);
    check("bp_mc_space", 64'(bus.o_ready), 64'h1);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check("bp_mc_valid", 64'(bus.o_valid), 64'h3);
    check("bp_mc_data", bus.o_data_bus, 64'h0000_0003_0000_0003);
    bus.i_ready = 2'b11;
    tick();
    check("bp_drained", 64'(bus.o_valid), 64'h0);

    // Full plus pop
    bus.i_ready = 2'b00;
    drive(1'b1, 2'b10, 32'h4);
    tick();
    drive(1'b1, 2'b10, 32'h5);
    tick();
    bus.i_ready = 2'b10;
    drive(1'b1, 2'b10, 32'h6);
    check("fp_ready0", 64'(bus.o_ready), 64'h0);
    tick();
    check("fp_pop_only", bus.o_data_bus, 64'h0000_0005_0000_0000);
    check("fp_ready1", 64'(bus.o_ready), 64'h1);
    tick();
    check("fp_push_next", bus.o_data_bus, 64'h0000_0006_0000_0000);

    // Drop
    bus.i_ready = 2'b00;
    drive(1'b1, 2'b00, 32'h77);
    check("drop_ready", 64'(bus.o_ready), 64'h1);
    tick();
    check("drop_valid", 64'(bus.o_valid), 64'h2);
    check("drop_data", bus.o_data_bus, 64'h0000_0006_0000_0000);

    // Enable low: no acceptance, drain continues
    bus.i_en = 1'b0;
    drive(1'b1, 2'b00, 32'h88);
    check("en_drop_ready", 64'(bus.o_ready), 64'h0);
    drive(1'b1, 2'b10, 32'h88);
    check("en_ready", 64'(bus.o_ready), 64'h0);
    bus.i_ready = 2'b10;
    tick();
    check("en_drained", 64'(bus.o_valid), 64'h0);
    check("en_ready_still", 64'(bus.o_ready), 64'h0);
    bus.i_en = 1'b1;
    #1;
    check("en_restored", 64'(bus.o_ready), 64'h1);

    // Reset discards stored words
    bus.i_ready = 2'b00;
    drive(1'b1, 2'b01, 32'h9);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check("pre_rst_valid", 64'(bus.o_valid), 64'h1);
    rst = 1'b1;
    bus.i_ready = 2'b01;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus.o_valid), 64'h0);
    check("mid_rst_data", bus.o_data_bus, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
